dmem_responder: RTL and testbench

//  Data-memory responder: the memory end of the core's D-Memory interface (address, write data, MemRead/MemWrite).

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_byte_lane.sv | 50 +++++
 rtl/dmem_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, access sizes,
// wait-counter width and the size decode used when a request is accepted.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } dmem_size_e;

  localparam int unsigned WAIT_W = 4;

  // Byte select wins over half select.
  function automatic dmem_size_e decode_size(input logic half, input logic byte_en);
    if (byte_en) return SZ_BYTE;
    else if (half) return SZ_HALF;
    else return SZ_WORD;
  endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Big-endian lane steering for sub-word accesses.
// Store merge: inserts right-justified data into the selected lane of the old word.
// Load extract: pulls the selected lane down to bit 0 and sign/zero extends it.
module dmem_byte_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  dmem_size_e  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [31:0] lane;

  // Lane position (offset 0 is the most significant lane) and the resulting merge/extract
  always_comb begin
    shift  = '0;
    mask   = '1;
    merged = word;
    loaded = '0;
    lane   = '0;
    case (size)
      SZ_BYTE: begin
        shift = {~offset, 3'b000};
        mask  = 32'h0000_00FF;
      end
      SZ_HALF: begin
        shift = {~offset[1], 4'b0000};
        mask  = 32'h0000_FFFF;
      end
      default: begin
        shift = '0;
        mask  = '1;
      end
    endcase
    merged = (word & ~(mask << shift)) | ((data & mask) << shift);
    lane   = (word >> shift) & mask;
    case (size)
      SZ_BYTE: loaded = sign_ext ? {{24{lane[7]}}, lane[7:0]} : lane;
      SZ_HALF: loaded = sign_ext ? {{16{lane[15]}}, lane[15:0]} : lane;
      default: loaded = lane;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the core's D-Memory interface: word-organised RAM serving
// word/half/byte loads and stores with WAIT_CYCLES wait states and a one-cycle
// MemReady pulse. Define DMEM_LLSC_EN to add an LL/SC reservation.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        AddrErr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  dmem_state_e state, next_state;
  logic [WAIT_W-1:0] cnt, cnt_n;

  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             rd_q, wr_q, sext_q, llsc_q;
  dmem_size_e       size_q;

  logic [IDX_W+1:0] a;
  logic [31:0]      wdata;
  logic             rd, wr, sext, llsc;
  dmem_size_e       size;

  logic [IDX_W-1:0] idx;
  logic [31:0]      cur_word, merged, loaded, result;
  logic             err, do_write, commit;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic             unused_addr_hi;

  logic [31:0] mem [DEPTH];

`ifdef DMEM_LLSC_EN
  logic             link_valid;
  logic [IDX_W-1:0] link_idx;
  logic             link_set, link_clr, sc_ok;
`endif

  assign unused_addr_hi = ^Addr[31:IDX_W+2];

  // With zero wait states the commit edge is also the accept edge, so the
  // live inputs stand in for the latch while in IDLE.
  always_comb begin
    if (state == IDLE) begin
      a     = Addr[IDX_W+1:0];
      wdata = WriteData;
      rd    = MemRead;
      wr    = MemWrite;
      sext  = MemSignExtend;
      llsc  = LLSC;
      size  = decode_size(MemHalf, MemByte);
    end else begin
      a     = addr_q;
      wdata = wdata_q;
      rd    = rd_q;
      wr    = wr_q;
      sext  = sext_q;
      llsc  = llsc_q;
      size  = size_q;
    end
  end

  assign idx      = a[IDX_W+1:2];
  assign cur_word = mem[idx];

  dmem_byte_lane u_lane (
    .word     (cur_word),
    .data     (wdata),
    .size     (size),
    .offset   (a[1:0]),
    .sign_ext (sext),
    .merged   (merged),
    .loaded   (loaded)
  );

  // Illegal request detection: misalignment, conflicting read/write, sub-word LL/SC
  always_comb begin
    err = rd && wr;
    case (size)
      SZ_HALF: if (a[0]) err = 1'b1;
      SZ_WORD: if (a[1:0] != 2'b00) err = 1'b1;
      default: ;
    endcase
`ifdef DMEM_LLSC_EN
    if (llsc && (size != SZ_WORD)) err = 1'b1;
`endif
  end

  // Access outcome at the commit edge: read result, write enable, reservation updates
  always_comb begin
    result   = '0;
    do_write = 1'b0;
`ifdef DMEM_LLSC_EN
    link_set = 1'b0;
    link_clr = 1'b0;
    sc_ok    = link_valid && (link_idx == idx);
    if (!err) begin
      if (rd) begin
        result   = loaded;
        link_set = llsc;
      end else if (wr) begin
        if (llsc) begin
          do_write = sc_ok;
          result   = {31'b0, sc_ok};
          link_clr = 1'b1;
        end else begin
          do_write = 1'b1;
          link_clr = sc_ok;
        end
      end
    end
`else
    if (!err) begin
      if (rd) begin
        result = loaded;
      end else if (wr) begin
        do_write = 1'b1;
        result   = {31'b0, llsc};
      end
    end
`endif
  end

  // Next-state and wait-counter logic
  always_comb begin
    next_state = state;
    cnt_n      = cnt;
    case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (WAIT_CYCLES == 0) begin
            next_state = RESP;
          end else begin
            next_state = ACCESS;
            cnt_n      = WAIT_INIT;
          end
        end
      end
      ACCESS: begin
        cnt_n = cnt - WAIT_W'(1);
        if (cnt_n == '0) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign commit = (next_state == RESP) && (state != RESP);

  // State, counter, request latch and committed response registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      llsc_q  <= 1'b0;
      size_q  <= SZ_WORD;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_n;
      if (state == IDLE && (MemRead || MemWrite)) begin
        addr_q  <= Addr[IDX_W+1:0];
        wdata_q <= WriteData;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        sext_q  <= MemSignExtend;
        llsc_q  <= LLSC;
        size_q  <= decode_size(MemHalf, MemByte);
      end
      if (commit) begin
        rdata_q <= result;
        err_q   <= err;
      end
    end
  end

`ifdef DMEM_LLSC_EN
  // LL/SC reservation tracking
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      link_valid <= 1'b0;
      link_idx   <= '0;
    end else if (commit) begin
      if (link_set) begin
        link_valid <= 1'b1;
        link_idx   <= idx;
      end else if (link_clr) begin
        link_valid <= 1'b0;
      end
    end
  end
`endif

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (commit && do_write) mem[idx] <= merged;
  end

  assign MemReady = (state == RESP);
  assign ReadData = (state == RESP) ? rdata_q : '0;
  assign AddrErr  = (state == RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (2, 0 and 3 wait states),
// expected responses queued when a request is driven and checked at MemReady.
// Expectations for LL/SC follow whether DMEM_LLSC_EN is defined.
module tb_dmem_responder;

  typedef struct {
    string       tag;
    logic        chk_rd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  localparam int WAITS [3] = '{2, 0, 3};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        half = 1'b0, byt = 1'b0, sx = 1'b0, ll = 1'b0;
  logic        mr [3] = '{1'b0, 1'b0, 1'b0};
  logic        mw [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] rdata [3];
  logic        rdy [3];
  logic        aerr [3];

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
    .CLK(CLK), .RST(RST), .Addr(addr), .WriteData(wdata),
    .MemRead(mr[0]), .MemWrite(mw[0]), .MemHalf(half), .MemByte(byt),
    .MemSignExtend(sx), .LLSC(ll),
    .ReadData(rdata[0]), .MemReady(rdy[0]), .AddrErr(aerr[0])
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
    .CLK(CLK), .RST(RST), .Addr(addr), .WriteData(wdata),
    .MemRead(mr[1]), .MemWrite(mw[1]), .MemHalf(half), .MemByte(byt),
    .MemSignExtend(sx), .LLSC(ll),
    .ReadData(rdata[1]), .MemReady(rdy[1]), .AddrErr(aerr[1])
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
    .CLK(CLK), .RST(RST), .Addr(addr), .WriteData(wdata),
    .MemRead(mr[2]), .MemWrite(mw[2]), .MemHalf(half), .MemByte(byt),
    .MemSignExtend(sx), .LLSC(ll),
    .ReadData(rdata[2]), .MemReady(rdy[2]), .AddrErr(aerr[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One request on instance s; latency counts rising edges from the accept edge
  // (inclusive) to the edge after which MemReady is high.
  task automatic req(input int s, input string tag,
                     input logic r, input logic w, input logic h, input logic b,
                     input logic x, input logic l,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   lat;
    bit   got;
    e.tag = tag; e.chk_rd = chk; e.rd = exp_rd; e.err = exp_err; e.lat = WAITS[s] + 1;
    sb.push_back(e);
    @(negedge CLK);
    addr = a; wdata = d; half = h; byt = b; sx = x; ll = l;
    mr[s] = r; mw[s] = w;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (rdy[s] === 1'b1) got = 1;
    end
    mr[s] = 1'b0; mw[s] = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL %s timeout: MemReady not seen within %0d cycles", e.tag, lat);
    end else begin
      check({e.tag, "/lat"}, 32'(lat), 32'(e.lat));
      check({e.tag, "/err"}, {31'b0, aerr[s]}, {31'b0, e.err});
      if (e.chk_rd) check({e.tag, "/rdata"}, rdata[s], e.rd);
      @(posedge CLK); #1;
      check({e.tag, "/pulse_end"}, {31'b0, rdy[s]}, 32'd0);
      check({e.tag, "/idle_out"}, rdata[s] | {31'b0, aerr[s]}, 32'd0);
    end
  endtask

  initial begin
    #2 RST = 1'b0;
    #1;
    check("reset/ready", {31'b0, rdy[0]}, 32'd0);
    check("reset/rdata", rdata[0], 32'd0);
    check("reset/err",   {31'b0, aerr[0]}, 32'd0);
    @(negedge CLK); RST = 1'b1;

    //       s  tag          rd wr h  b  sx ll addr          wdata         chk exp            err
    req(0, "sw10",         0, 1, 0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0);
    req(0, "lw10",         1, 0, 0, 0, 0, 0, 32'h10, 32'h0,        1, 32'hDEADBEEF, 0);

    req(0, "pre10",        0, 1, 0, 0, 0, 0, 32'h10, 32'h0,        0, 32'h0,        0);
    req(0, "sb11_7f",      0, 1, 0, 1, 0, 0, 32'h11, 32'h7F,       0, 32'h0,        0);
    req(0, "lw10_b",       1, 0, 0, 0, 0, 0, 32'h10, 32'h0,        1, 32'h007F0000, 0);
    req(0, "lb11_pos",     1, 0, 0, 1, 1, 0, 32'h11, 32'h0,        1, 32'h0000007F, 0);
    req(0, "sb11_80",      0, 1, 0, 1, 0, 0, 32'h11, 32'hFFFFFF80, 0, 32'h0,        0);
    req(0, "lb11_neg",     1, 0, 0, 1, 1, 0, 32'h11, 32'h0,        1, 32'hFFFFFF80, 0);
    req(0, "lbu11",        1, 0, 0, 1, 0, 0, 32'h11, 32'h0,        1, 32'h00000080, 0);
    req(0, "sh12",         0, 1, 1, 0, 0, 0, 32'h12, 32'h1234BEEF, 0, 32'h0,        0);
    req(0, "lh12_s",       1, 0, 1, 0, 1, 0, 32'h12, 32'h0,        1, 32'hFFFFBEEF, 0);
    req(0, "lhu12",        1, 0, 1, 0, 0, 0, 32'h12, 32'h0,        1, 32'h0000BEEF, 0);
    req(0, "lhu10",        1, 0, 1, 0, 0, 0, 32'h10, 32'h0,        1, 32'h00000080, 0);
    req(0, "lbu13",        1, 0, 0, 1, 0, 0, 32'h13, 32'h0,        1, 32'h000000EF, 0);
    req(0, "lw10_c",       1, 0, 0, 0, 0, 0, 32'h10, 32'h0,        1, 32'h0080BEEF, 0);

    req(0, "lh13_mis",     1, 0, 1, 0, 1, 0, 32'h13, 32'h0,        1, 32'h0,        1);
    req(0, "sw12_mis",     0, 1, 0, 0, 0, 0, 32'h12, 32'h0,        1, 32'h0,        1);
    req(0, "sh11_mis",     0, 1, 1, 0, 0, 0, 32'h11, 32'h0,        1, 32'h0,        1);
    req(0, "rdwr_both",    1, 1, 0, 0, 0, 0, 32'h10, 32'h0,        1, 32'h0,        1);
    req(0, "lw10_keep",    1, 0, 0, 0, 0, 0, 32'h10, 32'h0,        1, 32'h0080BEEF, 0);

    req(1, "w0_sw30",      0, 1, 0, 0, 0, 0, 32'h30, 32'h12345678, 0, 32'h0,        0);
    req(1, "w0_lw30",      1, 0, 0, 0, 0, 0, 32'h30, 32'h0,        1, 32'h12345678, 0);
    req(1, "w0_lb33",      1, 0, 0, 1, 1, 0, 32'h33, 32'h0,        1, 32'h00000078, 0);
    req(1, "w0_lh31_mis",  1, 0, 1, 0, 0, 0, 32'h31, 32'h0,        1, 32'h0,        1);
    req(2, "w3_sw30",      0, 1, 0, 0, 0, 0, 32'h30, 32'hCAFEF00D, 0, 32'h0,        0);
    req(2, "w3_lw30",      1, 0, 0, 0, 0, 0, 32'h30, 32'h0,        1, 32'hCAFEF00D, 0);
    req(2, "w3_lhu32",     1, 0, 1, 0, 0, 0, 32'h32, 32'h0,        1, 32'h0000F00D, 0);

    // Reset while a store is waiting in ACCESS: outputs drop, RAM keeps old word
    req(0, "pre40",        0, 1, 0, 0, 0, 0, 32'h40, 32'h11111111, 0, 32'h0,        0);
    @(negedge CLK);
    addr = 32'h40; wdata = 32'h22222222; half = 0; byt = 0; sx = 0; ll = 0; mw[0] = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    check("rst_mid/ready", {31'b0, rdy[0]}, 32'd0);
    check("rst_mid/out",   rdata[0] | {31'b0, aerr[0]}, 32'd0);
    mw[0] = 1'b0;
    @(negedge CLK); RST = 1'b1;
    req(0, "rst_mid/word", 1, 0, 0, 0, 0, 0, 32'h40, 32'h0,        1, 32'h11111111, 0);

`ifdef DMEM_LLSC_EN
    req(0, "pre20",        0, 1, 0, 0, 0, 0, 32'h20, 32'h9,        0, 32'h0,        0);
    req(0, "ll20",         1, 0, 0, 0, 0, 1, 32'h20, 32'h0,        1, 32'h9,        0);
    req(0, "sc20_ok",      0, 1, 0, 0, 0, 1, 32'h20, 32'h5,        1, 32'h1,        0);
    req(0, "lw20_5",       1, 0, 0, 0, 0, 0, 32'h20, 32'h0,        1, 32'h5,        0);
    req(0, "ll20_b",       1, 0, 0, 0, 0, 1, 32'h20, 32'h0,        1, 32'h5,        0);
    req(0, "sw20_7",       0, 1, 0, 0, 0, 0, 32'h20, 32'h7,        0, 32'h0,        0);
    req(0, "sc20_fail",    0, 1, 0, 0, 0, 1, 32'h20, 32'h8,        1, 32'h0,        0);
    req(0, "lw20_7",       1, 0, 0, 0, 0, 0, 32'h20, 32'h0,        1, 32'h7,        0);
    req(0, "sc20_nolink",  0, 1, 0, 0, 0, 1, 32'h20, 32'h9,        1, 32'h0,        0);
    req(0, "ll_byte_mis",  1, 0, 0, 1, 0, 1, 32'h20, 32'h0,        1, 32'h0,        1);
    req(0, "lw20_7b",      1, 0, 0, 0, 0, 0, 32'h20, 32'h0,        1, 32'h7,        0);
`else
    req(0, "sc20_plain",   0, 1, 0, 0, 0, 1, 32'h20, 32'h5,        1, 32'h1,        0);
    req(0, "lw20_5",       1, 0, 0, 0, 0, 0, 32'h20, 32'h0,        1, 32'h5,        0);
    req(0, "ll20_plain",   1, 0, 0, 0, 0, 1, 32'h20, 32'h0,        1, 32'h5,        0);
    req(0, "sbc21_plain",  0, 1, 0, 1, 0, 1, 32'h21, 32'hAB,       1, 32'h1,        0);
    req(0, "lw20_ab",      1, 0, 0, 0, 0, 0, 32'h20, 32'h0,        1, 32'h00AB0005, 0);
`endif

    req(0, "sw1000_wrap",  0, 1, 0, 0, 0, 0, 32'h1000, 32'hA5,     0, 32'h0,        0);
    req(0, "lw0_wrap",     1, 0, 0, 0, 0, 0, 32'h0,    32'h0,      1, 32'h000000A5, 0);
    req(0, "lw1010_wrap",  1, 0, 0, 0, 0, 0, 32'h1010, 32'h0,      1, 32'h0080BEEF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
